// File: rtl/montgomery_arbiter.sv
// montgomery_arbiter
//   Shares one montgomery multiplier between two requesters. One
//   multiplication is served at a time. Requesters are picked round-robin
//   when both ask at once.
//
//   Per request: register operands (LOAD), pulse mult_start (START), wait
//   for mult_done (WAIT), then return the result with a one-cycle done
//   pulse (RESP).
//
// Ports
//   clk, resetn                     clock (rising edge), sync active-low reset
//   req{0,1}_valid                  request, held until the matching done
//   req{0,1}_a, req{0,1}_b          operands, stable while valid is high
//   req{0,1}_grant                  high from LOAD through RESP for the served port
//   req{0,1}_done                   one-cycle pulse; result valid in the same cycle
//   req{0,1}_result                 per-port result register (holds last result)
//   mult_start                      one-cycle start pulse to the multiplier
//   mult_a, mult_b                  registered multiplier operands
//   mult_result, mult_done          multiplier result and completion
//   busy                            high in every state except IDLE
//
//   The modulus bus goes straight to the multiplier and does not pass
//   through this block. Every output is a register, so there is no
//   combinational path from reqN_valid or mult_done to any output.
module montgomery_arbiter #(
  parameter int WIDTH = 512
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req0_valid,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req0_grant,
  output logic             req1_grant,
  output logic             req0_done,
  output logic             req1_done,
  output logic [WIDTH-1:0] req0_result,
  output logic [WIDTH-1:0] req1_result,
  output logic             mult_start,
  output logic [WIDTH-1:0] mult_a,
  output logic [WIDTH-1:0] mult_b,
  input  logic [WIDTH-1:0] mult_result,
  input  logic             mult_done,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state;
  logic   sel;   // requester currently being served
  logic   last;  // requester served most recently

  // Round-robin pick: a lone requester wins outright. On contention, the
  // requester that was not served last wins.
  function automatic logic pick(input logic v0, input logic v1, input logic lst);
    logic p;
    if (v0 && v1) begin
      p = ~lst;
    end else begin
      p = v1;
    end
    return p;
  endfunction

  logic nxt_sel;
  assign nxt_sel = pick(req0_valid, req1_valid, last);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= S_IDLE;
      sel         <= 1'b0;
      last        <= 1'b1;   // requester 0 wins the first contention
      req0_grant  <= 1'b0;
      req1_grant  <= 1'b0;
      req0_done   <= 1'b0;
      req1_done   <= 1'b0;
      mult_start  <= 1'b0;
      busy        <= 1'b0;
      mult_a      <= '0;
      mult_b      <= '0;
      req0_result <= '0;
      req1_result <= '0;
    end else begin
      // The pulse outputs default low. They are raised only for the one
      // state that owns them.
      mult_start <= 1'b0;
      req0_done  <= 1'b0;
      req1_done  <= 1'b0;

      case (state)
        S_IDLE: begin
          if (req0_valid || req1_valid) begin
            sel        <= nxt_sel;
            req0_grant <= ~nxt_sel;
            req1_grant <= nxt_sel;
            busy       <= 1'b1;
            state      <= S_LOAD;
          end
        end

        // Operands are captured here and are visible together with
        // mult_start in the START cycle.
        S_LOAD: begin
          mult_a     <= sel ? req1_a : req0_a;
          mult_b     <= sel ? req1_b : req0_b;
          mult_start <= 1'b1;
          state      <= S_START;
        end

        S_START: begin
          state <= S_WAIT;
        end

        // Result and done land together, so the done in RESP coincides
        // with the updated result register.
        S_WAIT: begin
          if (mult_done) begin
            if (sel) begin
              req1_result <= mult_result;
              req1_done   <= 1'b1;
            end else begin
              req0_result <= mult_result;
              req0_done   <= 1'b1;
            end
            state <= S_RESP;
          end
        end

        S_RESP: begin
          last       <= sel;
          req0_grant <= 1'b0;
          req1_grant <= 1'b0;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
